// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled: 2-flop synchronizer, mid-bit sampling of
// start/data/stop bits, one-cycle done strobe with framing-error flag.
module uart_rx #(
    parameter int DATA_BIT = 8,
    parameter int STOP_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bd_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BIT - 1);
    localparam logic [2:0] D_LAST    = 3'(DATA_BIT - 1);
    localparam int         SHIFT     = 8 - DATA_BIT;

    state_t     state_q;
    logic       rx_m_q, rx_s_q;
    logic [4:0] tick_q;
    logic [2:0] d_q;
    logic [7:0] shreg_q;
    logic       err_q;
    logic [7:0] dout_q;
    logic       done_q, ferr_q, busy_q;
    logic       err_d;

    // The last stop tick is always a sample point, so the final flag folds in the live sample.
    assign err_d = err_q | ~rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            tick_q  <= '0;
            d_q     <= '0;
            shreg_q <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bd_tick) begin
                        if (tick_q == 5'd7) begin
                            if (!rx_s_q) begin
                                state_q <= DATA;
                                tick_q  <= '0;
                                d_q     <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (bd_tick) begin
                        if (tick_q == 5'd15) begin
                            tick_q  <= '0;
                            shreg_q <= {rx_s_q, shreg_q[7:1]};
                            if (d_q == D_LAST) begin
                                state_q <= STOP;
                                err_q   <= 1'b0;
                            end else begin
                                d_q <= d_q + 3'd1;
                            end
                        end else begin
                            tick_q <= tick_q + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (bd_tick) begin
                        if (tick_q == STOP_LAST) begin
                            dout_q  <= shreg_q >> SHIFT;
                            ferr_q  <= err_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            if (tick_q == 5'd15) err_q <= err_d;
                            tick_q <= tick_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and a 7-data/2-stop receiver share one line; a
// tick-index model predicts every output each cycle, plus literal spot checks.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       bd_tick;
    logic       rx;
    logic [7:0] dout_a, dout_b;
    logic       done_a, done_b, ferr_a, ferr_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    uart_rx #(.DATA_BIT(8), .STOP_BIT(1)) dut_a (
        .clk(clk), .rst(rst), .bd_tick(bd_tick), .rx(rx),
        .dout(dout_a), .rx_done(done_a), .frame_err(ferr_a), .busy(busy_a));
    uart_rx #(.DATA_BIT(7), .STOP_BIT(2)) dut_b (
        .clk(clk), .rst(rst), .bd_tick(bd_tick), .rx(rx),
        .dout(dout_b), .rx_done(done_b), .frame_err(ferr_b), .busy(busy_b));

    always #5 clk = ~clk;

    // bd_tick every 4 clk, changed just after the active edge
    initial begin
        int div;
        div = 0;
        bd_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            bd_tick = (div == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: counts bd_ticks since start detect; samples at 8, 8+16k.
    logic       m_s1, m_s2, model_ok = 1'b0, tick_e;
    logic       m_act [2];
    int         m_k   [2];
    logic [7:0] m_bits[2];
    logic       m_err [2];
    logic [7:0] e_dout[2];
    logic       e_ferr[2], e_done[2];

    always @(posedge clk) begin
        logic rs;
        int nd, ns;
        rs = m_s2;
        tick_e = bd_tick;
        if (rst) begin
            m_s1 = 1'b1;
            m_s2 = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_k[i] = 0; m_bits[i] = '0; m_err[i] = 1'b0;
                e_dout[i] = '0; e_ferr[i] = 1'b0; e_done[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                nd = (i == 0) ? 8 : 7;
                ns = (i == 0) ? 1 : 2;
                e_done[i] = 1'b0;
                if (!m_act[i]) begin
                    if (!rs) begin
                        m_act[i] = 1'b1; m_k[i] = 0; m_bits[i] = '0; m_err[i] = 1'b0;
                    end
                end else if (bd_tick) begin
                    m_k[i]++;
                    if (m_k[i] == 8) begin
                        if (rs) m_act[i] = 1'b0;
                    end else if (m_k[i] > 8 && m_k[i] <= 8 + 16 * nd) begin
                        if ((m_k[i] - 8) % 16 == 0) m_bits[i][(m_k[i] - 8) / 16 - 1] = rs;
                    end else if (m_k[i] > 8 + 16 * nd && (m_k[i] - 8 - 16 * nd) % 16 == 0) begin
                        if (!rs) m_err[i] = 1'b1;
                        if (m_k[i] == 8 + 16 * nd + 16 * ns) begin
                            e_done[i] = 1'b1;
                            e_dout[i] = m_bits[i];
                            e_ferr[i] = m_err[i];
                            m_act[i]  = 1'b0;
                        end
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = rx;
        end
        model_ok = 1'b1;
    end

    int         n_done[2] = '{0, 0};
    logic [7:0] last_dout[2];
    logic       last_ferr[2];
    int         len_b = 0, gap_a = 0, last_gap_a = 0;
    logic       pbusy_b = 1'b0;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("doutA", dout_a, e_dout[0]);
            chk("doneA", done_a, e_done[0]);
            chk("ferrA", ferr_a, e_ferr[0]);
            chk("busyA", busy_a, m_act[0]);
            chk("doutB", dout_b, e_dout[1]);
            chk("doneB", done_b, e_done[1]);
            chk("ferrB", ferr_b, e_ferr[1]);
            chk("busyB", busy_b, m_act[1]);
            if (pbusy_b && tick_e) len_b++;
            if (busy_b && !pbusy_b) len_b = 0;
            pbusy_b = busy_b;
            if (tick_e) gap_a++;
            if (done_a) begin
                n_done[0]++; last_dout[0] = dout_a; last_ferr[0] = ferr_a;
                last_gap_a = gap_a; gap_a = 0;
            end
            if (done_b) begin
                n_done[1]++; last_dout[1] = dout_b; last_ferr[1] = ferr_b;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (bd_tick) c++;
        end
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int nb, input int ns, input logic [1:0] sv);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        for (int j = 0; j < ns; j++) begin
            rx = sv[j];
            wait_ticks(16);
        end
        rx = 1'b1;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        logic [7:0] d;
        int nb, ns;
        logic [1:0] sv;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", dout_a, 8'h00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_ticks(10);

        send(8'h55, 8, 1, 2'b11);
        wait_ticks(4);
        chk("basic_n", n_done[0], 1);
        chk("basic_dout", last_dout[0], 8'h55);
        chk("basic_ferr", last_ferr[0], 1'b0);
        chk("basic_busy", busy_a, 1'b0);
        wait_ticks(40);

        send(8'hA3, 8, 1, 2'b11);
        chk("b2b_first", last_dout[0], 8'hA3);
        send(8'h0F, 8, 1, 2'b11);
        chk("b2b_second", last_dout[0], 8'h0F);
        chk("b2b_gap", last_gap_a, 160);
        chk("b2b_n", n_done[0], 3);
        wait_ticks(20);

        n0 = n_done[0];
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(20);
        chk("glitch_n", n_done[0], n0);
        chk("glitch_busy", busy_a, 1'b0);
        chk("glitch_dout", dout_a, 8'h0F);

        send(8'hC6, 8, 1, 2'b00);
        chk("ferr_dout", last_dout[0], 8'hC6);
        chk("ferr_set", last_ferr[0], 1'b1);
        wait_ticks(200);
        send(8'h12, 8, 1, 2'b11);
        wait_ticks(4);
        chk("ferr_clr_dout", last_dout[0], 8'h12);
        chk("ferr_clr", last_ferr[0], 1'b0);
        wait_ticks(40);

        n0 = n_done[0];
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(56);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_dout", dout_a, 8'h00);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_ferr", ferr_a, 1'b0);
        wait_ticks(200);
        chk("mid_rst_n", n_done[0], n0);
        send(8'h3C, 8, 1, 2'b11);
        wait_ticks(4);
        chk("post_rst_dout", last_dout[0], 8'h3C);
        wait_ticks(40);

        send(8'h41, 7, 2, 2'b11);
        chk("p7_dout", last_dout[1], 8'h41);
        chk("p7_ferr", last_ferr[1], 1'b0);
        chk("p7_len", len_b, 152);
        wait_ticks(40);
        send(8'h41, 7, 2, 2'b01);
        chk("p7_ferr2", last_ferr[1], 1'b1);
        chk("p7_dout2", last_dout[1], 8'h41);
        wait_ticks(200);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) begin
                rx = 1'b0;
                wait_ticks($urandom_range(1, 6));
                rx = 1'b1;
                wait_ticks(20);
            end
            d  = 8'($urandom);
            nb = $urandom_range(7, 8);
            ns = $urandom_range(1, 2);
            sv[0] = ($urandom_range(0, 7) != 0);
            sv[1] = ($urandom_range(0, 7) != 0);
            send(d, nb, ns, sv);
            if (sv[0] == 1'b0 || (ns == 2 && sv[1] == 1'b0)) wait_ticks(200);
            else wait_ticks($urandom_range(0, 20));
        end
        wait_ticks(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver with 16x oversampling, counterpart to the UART transmitter on the same serial link. Synchronizes the asynchronous `rx` line and validates the start bit at its midpoint. Samples each data bit LSB-first at mid-bit and checks the stop bit(s). Delivers each received byte on a parallel output with a one-cycle done strobe and a framing-error flag. Sits between the board-level RX pin and the RX FIFO, sharing the baud-rate tick generator with the transmitter.

## Interface
- DATA_BIT, 8, number of data bits per frame, legal 5..8
- STOP_BIT, 1, number of stop bits, legal 1 or 2
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- bd_tick  input  1  single-cycle pulse at 16x baud rate
- rx  input  1  asynchronous serial line, idle high
- dout  output  8  received data, right-aligned, unused upper bits 0
- rx_done  output  1  one-cycle strobe, dout/frame_err valid
- frame_err  output  1  stop-bit sample was low; valid with rx_done, held until next rx_done
- busy  output  1  high in any state other than IDLE

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1). All decisions below use the synchronized value `rx_s`.
- Counters: `tick_cnt` is 5 bits (counts to 31 for 2 stop bits), `d_cnt` is 3 bits. Both advance only on cycles where bd_tick=1.
- IDLE:
  - If rx_s=0, go to START with tick_cnt=0.
  - bd_tick is not needed to leave IDLE.
- START, on each bd_tick:
  - If tick_cnt=7 and rx_s=0: go to DATA with tick_cnt=0 and d_cnt=0.
  - If tick_cnt=7 and rx_s=1: this is a glitch or false start. Return to IDLE with no strobe and outputs unchanged.
  - Otherwise tick_cnt+1.
- DATA, on each bd_tick:
  - If tick_cnt=15: set tick_cnt=0 and shift `shreg <= {rx_s, shreg[7:1]}`.
  - Then, if d_cnt=DATA_BIT-1, go to STOP with tick_cnt=0; otherwise d_cnt+1.
  - If tick_cnt≠15: tick_cnt+1.
- STOP, on each bd_tick:
  - If tick_cnt=15 or tick_cnt=31: sample rx_s. Any low sample sets an internal error bit, which is cleared on entry to STOP.
  - If tick_cnt=16*STOP_BIT-1: load `dout <= shreg >> (8-DATA_BIT)`, set frame_err from the error bit (including the current sample), pulse rx_done, and go to IDLE.
  - Otherwise tick_cnt+1.
- A frame with frame_err=1 still delivers dout. Discarding it is the consumer's decision.
- Back-to-back frames: after STOP→IDLE, a low rx_s immediately starts the next frame. No idle gap is required.
- The receiver has no flow control. If the consumer misses a strobe, dout is overwritten by the next frame.
- Reset: state=IDLE, tick_cnt=0, d_cnt=0, shreg=0, dout=0x00, rx_done=0, frame_err=0, busy=0. Reset mid-frame abandons the frame with no strobe.

## Timing
- Input latency: 2 clk synchronizer delay from rx to rx_s.
- Start detect: IDLE→START one clk after rx_s falls.
- Start validation: 8 bd_ticks after entering START, i.e. mid-start-bit.
- Data sampling: each data bit is sampled 16 bd_ticks after the previous sample point, i.e. at mid-bit.
- Done strobe: rx_done is registered. It is high for exactly one clk, in the cycle after the bd_tick that ends the last stop-bit interval. dout and frame_err update in that same cycle.
- busy falls in the same cycle rx_done rises.
- Frame length from start-detect to rx_done: 8 + 16*DATA_BIT + 16*STOP_BIT bd_ticks, plus 1 clk.
- bd_tick during IDLE is ignored. A bd_tick coincident with the rx_s falling edge does not count toward START.
- rst has priority over all other inputs in the same cycle.

## Test plan
- **Basic frame:** DATA_BIT=8, STOP_BIT=1, bd_tick every 4 clk, send 0x55 → exactly one rx_done pulse, dout=0x55, frame_err=0, busy low afterwards.
- **Back-to-back frames:** send 0xA3 then 0x0F with no idle gap → two rx_done pulses 160 bd_ticks apart, dout=0xA3 then 0x0F.
- **Glitch rejection:** drive rx low for 3 bd_ticks, then high → no rx_done, busy returns to 0 after tick 7, dout unchanged.
- **Framing error:** send 0xC6 with the stop bit held low → rx_done=1, dout=0xC6, frame_err=1. The next clean frame 0x12 → frame_err=0.
- **Reset mid-frame:** assert rst for 1 clk during the 4th data bit of 0xFF → all outputs 0 the next cycle, no rx_done for the aborted frame. A following 0x3C is received correctly.
- **Parameter variant:** DATA_BIT=7, STOP_BIT=2, send 0x41 → dout=0x41 (bit 7 = 0), rx_done occurs 8+112+32 bd_ticks after start-detect. A low second stop bit → frame_err=1.
